// File: rtl/demux8way16_wr_sched_pkg.sv
// Shared types and helpers for the demux write scheduler.
package demux8way16_wr_sched_pkg;

  localparam int SEL_W = 3;
  localparam int NDEST = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Decode a 3-bit destination index into a one-hot load vector.
  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    onehot8 = 8'b0000_0001 << sel;
  endfunction

endpackage

// File: rtl/demux8way16_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module demux8way16_wr_sched_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx
);

  // Walk upward from ptr, wrapping, and keep only the first hit.
  always_comb begin : p_arb
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = 3'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux8way16_wr_sched.sv
// Round-robin write scheduler for the 8-way demux/register-bank path,
// with a back-to-back clear sequencer that zeroes all destinations.
module demux8way16_wr_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int NDEST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_sel,
  input  logic [W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              clear_start,
  output logic              busy,
  output logic              wr_valid,
  output logic [2:0]        wr_sel,
  output logic [NDEST-1:0]  wr_load,
  output logic [W-1:0]      wr_data,
  output logic [2:0]        wr_grant_id
);
  import demux8way16_wr_sched_pkg::*;

  state_e             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               wr_valid_q, wr_valid_d;
  logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
  logic [NDEST-1:0]   wr_load_q, wr_load_d;
  logic [W-1:0]       wr_data_q, wr_data_d;
  logic [2:0]         wr_gid_q, wr_gid_d;

  logic [NREQ-1:0]    arb_grant;
  logic [2:0]         arb_idx;
  logic               grant_en;
  logic               xfer;

  demux8way16_wr_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Grants only in IDLE; a clear request in the same cycle suppresses them,
  // and ready is forced low while reset is asserted.
  assign grant_en  = rst_n && (state_q == IDLE) && !clear_start;
  assign req_ready = grant_en ? arb_grant : '0;
  assign xfer      = |req_ready;

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    wr_valid_d = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_data_d  = wr_data_q;
    wr_gid_d   = wr_gid_q;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (xfer) begin
          wr_valid_d = 1'b1;
          wr_sel_d   = req_sel[3*int'(arb_idx) +: 3];
          wr_data_d  = req_data[W*int'(arb_idx) +: W];
          wr_gid_d   = arb_idx;
          rr_ptr_d   = (arb_idx == 3'(NREQ-1)) ? 3'd0 : arb_idx + 3'd1;
        end
      end
      CLEAR: begin
        // clear_start is ignored here: the sequence neither restarts nor queues.
        wr_valid_d = 1'b1;
        wr_sel_d   = clr_cnt_q;
        wr_data_d  = '0;
        wr_gid_d   = 3'd0;
        clr_cnt_d  = clr_cnt_q + 3'd1;
        if (clr_cnt_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_load_d = wr_valid_d ? onehot8(wr_sel_d) : '0;
  end

  // State and registered outputs; reset aborts any clear or grant in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      clr_cnt_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_sel_q   <= '0;
      wr_load_q  <= '0;
      wr_data_q  <= '0;
      wr_gid_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_sel_q   <= wr_sel_d;
      wr_load_q  <= wr_load_d;
      wr_data_q  <= wr_data_d;
      wr_gid_q   <= wr_gid_d;
    end
  end

  assign busy        = (state_q == CLEAR);
  assign wr_valid    = wr_valid_q;
  assign wr_sel      = wr_sel_q;
  assign wr_load     = wr_load_q;
  assign wr_data     = wr_data_q;
  assign wr_grant_id = wr_gid_q;

endmodule

// File: tb/tb_demux8way16_wr_sched.sv
// Self-checking bench: randomized requesters against a transaction-level model.
module tb_demux8way16_wr_sched;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_sel;
  logic [W*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              clear_start;
  logic              busy;
  logic              wr_valid;
  logic [2:0]        wr_sel;
  logic [7:0]        wr_load;
  logic [W-1:0]      wr_data;
  logic [2:0]        wr_grant_id;

  always #5 clk = ~clk;

  demux8way16_wr_sched #(.NREQ(NREQ), .W(W), .NDEST(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_sel     (req_sel),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .busy        (busy),
    .wr_valid    (wr_valid),
    .wr_sel      (wr_sel),
    .wr_load     (wr_load),
    .wr_data     (wr_data),
    .wr_grant_id (wr_grant_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester side: pending flag plus held sel/data per requester.
  logic [NREQ-1:0] pend;
  logic [2:0]      rsel [NREQ];
  logic [W-1:0]    rdat [NREQ];

  // Reference model: pointer, clear progress, and expected write outputs.
  int         m_ptr;
  bit         m_clr;
  int         m_cnt;
  bit         e_valid;
  logic [2:0] e_sel;
  logic [W-1:0] e_data;
  logic [2:0] e_gid;

  function automatic logic [NREQ-1:0] model_ready(input bit clr);
    logic [NREQ-1:0] r;
    r = '0;
    if (!m_clr && !clr) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (r == '0 && pend[i]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_step(input logic [NREQ-1:0] rdy, input bit clr);
    if (m_clr) begin
      e_valid = 1'b1; e_sel = 3'(m_cnt); e_data = '0; e_gid = 3'd0;
      m_cnt++;
      if (m_cnt == 8) m_clr = 1'b0;
    end else if (clr) begin
      m_clr = 1'b1; m_cnt = 0; e_valid = 1'b0;
    end else if (rdy != '0) begin
      for (int i = 0; i < NREQ; i++)
        if (rdy[i]) begin
          e_valid = 1'b1; e_sel = rsel[i]; e_data = rdat[i]; e_gid = 3'(i);
          m_ptr = (i + 1) % NREQ;
        end
    end else begin
      e_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_clr = 1'b0; m_cnt = 0;
    e_valid = 1'b0; e_sel = '0; e_data = '0; e_gid = '0;
  endtask

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_sel[3*i +: 3]  = rsel[i];
      req_data[W*i +: W] = rdat[i];
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eload;
    eload = e_valid ? (8'b1 << e_sel) : 8'b0;
    chk("wr_valid", wr_valid, e_valid);
    chk("wr_load", wr_load, eload);
    chk("wr_sel", wr_sel, e_sel);
    chk("wr_data", wr_data, e_data);
    chk("wr_grant_id", wr_grant_id, e_gid);
    chk("busy", busy, m_clr);
  endtask

  // One clock: check combinational ready, clock, check registered outputs,
  // retire handshaken requests and optionally issue new random ones.
  task automatic cycle(input bit clr, input int prob);
    logic [NREQ-1:0] erdy, drdy;
    clear_start = clr;
    drive();
    #1;
    erdy = model_ready(clr);
    drdy = req_ready;
    chk("req_ready", drdy, erdy);
    @(posedge clk); #1;
    model_step(erdy, clr);
    pend = pend & ~drdy;
    check_outputs();
    clear_start = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && $urandom_range(99) < prob) begin
        pend[i] = 1'b1;
        rsel[i] = 3'($urandom_range(7));
        rdat[i] = W'($urandom);
      end
    drive();
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; clear_start = 1'b0;
    pend = '1;
    for (int i = 0; i < NREQ; i++) begin rsel[i] = 3'(i); rdat[i] = W'(16'h100 + i); end
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset state with all requesters valid.
    chk("rst_ready", req_ready, '0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_load", wr_load, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", req_ready, 4'b0001);
    // Drain the initial requests.
    repeat (5) cycle(1'b0, 0);

    // Single request from requester 2.
    pend = 4'b0100; rsel[2] = 3'd5; rdat[2] = 16'hBEEF;
    cycle(1'b0, 0);
    chk("single_load", wr_load, 8'b0010_0000);
    chk("single_gid", wr_grant_id, 3'd2);
    chk("single_data", wr_data, 16'hBEEF);
    cycle(1'b0, 0);
    chk("single_idle", wr_valid, 1'b0);

    // Fairness: all valid continuously; starting pointer is 3 after requester 2.
    pend = '1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 100);
      if (wr_valid) cnt++;
    end
    chk("fair_writes", cnt, 8);
    pend = '0;
    repeat (3) cycle(1'b0, 0);

    // Clear with requester 1 held valid.
    pend = 4'b0010; rsel[1] = 3'd6; rdat[1] = 16'hA5A5;
    cnt = 0;
    cycle(1'b1, 0);
    if (busy) cnt++;
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 0);
      if (busy) cnt++;
    end
    chk("clear_busy_len", cnt, 8);
    chk("after_clear_gid", wr_grant_id, 3'd1);
    chk("after_clear_data", wr_data, 16'hA5A5);

    // Collision with requester 0, plus an ignored second clear_start.
    pend = 4'b0001; rsel[0] = 3'd2; rdat[0] = 16'h1234;
    cnt = 0;
    cycle(1'b1, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(k == 3, 0);
      if (wr_valid && wr_data == '0) cnt++;
    end
    chk("collide_clear_writes", cnt, 8);
    chk("collide_served", pend, 4'b0000);

    // Reset mid-clear at clr_cnt = 3.
    pend = '1;
    cycle(1'b1, 0);
    repeat (3) cycle(1'b0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_wr_valid", wr_valid, 1'b0);
    chk("midrst_wr_sel", wr_sel, 3'd0);
    chk("midrst_wr_load", wr_load, 8'h00);
    chk("midrst_wr_data", wr_data, 16'h0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", req_ready, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_first_grant", req_ready, 4'b0001);
    repeat (6) cycle(1'b0, 0);

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(99) < 3, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
